// File: rtl/hazard_fwd_scoreboard_pkg.sv
// Shared types for the ID-stage hazard/forwarding scoreboard: forwarding-source codes
// and the shadow-pipe entry layout.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // rd is stored zero-extended so one entry type serves any REG_AW up to this width
  localparam int unsigned RD_MAX_W = 8;

  typedef struct packed {
    logic                v;
    logic [RD_MAX_W-1:0] rd;
    logic                rf_en;
    logic                load;
  } shadow_t;

endpackage

// File: rtl/hazard_fwd_scoreboard_if.sv
// ID-stage decode/flush inputs and forwarding/stall outputs of the hazard scoreboard.
interface hazard_fwd_scoreboard_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned REG_AW  = 4
);
  logic                        flush;
  logic                        id_valid;
  logic [REG_AW-1:0]           id_rd;
  logic                        id_rf_en;
  logic                        id_load;
  logic [NUM_SRC*REG_AW-1:0]   id_src;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [2*NUM_SRC-1:0]        fwd_sel;
  logic                        stall;
  logic                        bubble;
  logic                        mem_load_fwd;

  modport master (
    output flush, id_valid, id_rd, id_rf_en, id_load, id_src, id_src_used,
    input  fwd_sel, stall, bubble, mem_load_fwd
  );

  modport slave (
    input  flush, id_valid, id_rd, id_rf_en, id_load, id_src, id_src_used,
    output fwd_sel, stall, bubble, mem_load_fwd
  );
endinterface

// File: rtl/hazard_fwd_scoreboard_src_match.sv
// Per-operand matcher: picks the youngest shadow stage writing this source and flags
// a match against a load whose data is not yet forwardable.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned NO_FWD_REG = 15,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  shadow_t           ex,
  input  shadow_t           mem,
  input  shadow_t           wb,
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  output logic [1:0]        fwd_sel,
  output logic              load_hit
);

  logic [RD_MAX_W-1:0] src_x;
  logic                eligible;
  logic                m_ex, m_mem, m_wb;

  assign src_x    = RD_MAX_W'(src);
  assign eligible = used & (src != REG_AW'(NO_FWD_REG));
  assign m_ex     = eligible & ex.v  & ex.rf_en  & (ex.rd  == src_x);
  assign m_mem    = eligible & mem.v & mem.rf_en & (mem.rd == src_x);
  assign m_wb     = eligible & wb.v  & wb.rf_en  & (wb.rd  == src_x);

  always_comb begin
    fwd_sel = FWD_RF;
    if (m_ex)       fwd_sel = FWD_EX;
    else if (m_mem) fwd_sel = FWD_MEM;
    else if (m_wb)  fwd_sel = FWD_WB;
  end

  // A stage k steps past EX still holds unready load data while k < LOAD_LAT
  assign load_hit = (m_ex  & ex.load  & (LOAD_LAT >= 1))
                  | (m_mem & mem.load & (LOAD_LAT >= 2))
                  | (m_wb  & wb.load  & (LOAD_LAT >= 3));

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// ID-stage forwarding selector and load-use stall generator with its own EX/MEM/WB
// shadow pipe. Optional perf counters via `define HAZ_PERF_CNT_EN.
module hazard_fwd_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned NO_FWD_REG = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  hazard_fwd_scoreboard_if.slave bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            fwd_cnt
`endif
);

  shadow_t                ex_q, mem_q, wb_q;
  shadow_t                id_entry;
  logic [NUM_SRC-1:0]     load_hit;
  logic [2*NUM_SRC-1:0]   fwd_sel_w;
  logic                   stall_w;
  logic                   issue;

  always_comb begin
    id_entry       = '0;
    id_entry.v     = 1'b1;
    id_entry.rd    = RD_MAX_W'(bus.id_rd);
    id_entry.rf_en = bus.id_rf_en;
    id_entry.load  = bus.id_load;
  end

  assign issue = bus.id_valid & ~stall_w & ~bus.flush;

  // Downstream stages always advance; a stalled or flushed ID inserts a bubble into EX
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= issue ? id_entry : '0;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .REG_AW    (REG_AW),
      .NO_FWD_REG(NO_FWD_REG),
      .LOAD_LAT  (LOAD_LAT)
    ) u_match (
      .ex      (ex_q),
      .mem     (mem_q),
      .wb      (wb_q),
      .src     (bus.id_src[i*REG_AW +: REG_AW]),
      .used    (bus.id_src_used[i]),
      .fwd_sel (fwd_sel_w[2*i +: 2]),
      .load_hit(load_hit[i])
    );
  end

  assign stall_w          = bus.id_valid & ~bus.flush & (|load_hit);
  assign bus.stall        = stall_w;
  assign bus.bubble       = stall_w;
  assign bus.fwd_sel      = fwd_sel_w;
  assign bus.mem_load_fwd = mem_q.v & mem_q.load;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall_w && (stall_cnt != '1))    stall_cnt <= stall_cnt + 32'd1;
      if ((|fwd_sel_w) && (fwd_cnt != '1)) fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench: two scoreboards (LOAD_LAT=1 and 2) share one ID stream and are compared every
// cycle to an instruction-history model, plus directed load-use/flush/reset scenarios.
module tb_hazard_fwd_scoreboard;

  typedef struct {
    bit v;
    int rd;
    bit rf_en;
    bit load;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_fwd_scoreboard_if #(.NUM_SRC(3), .REG_AW(4)) ifa ();
  hazard_fwd_scoreboard_if #(.NUM_SRC(3), .REG_AW(4)) ifb ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_a, fwd_cnt_a, stall_cnt_b, fwd_cnt_b;
`endif

  hazard_fwd_scoreboard #(.NUM_SRC(3), .REG_AW(4), .LOAD_LAT(1), .NO_FWD_REG(15)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt_a), .fwd_cnt(fwd_cnt_a)
`endif
  );

  hazard_fwd_scoreboard #(.NUM_SRC(3), .REG_AW(4), .LOAD_LAT(2), .NO_FWD_REG(15)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt_b), .fwd_cnt(fwd_cnt_b)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // hist[d][a]: what entered EX a+1 cycles ago in DUT d (a=0 -> EX, 1 -> MEM, 2 -> WB)
  ent_t        hist[2][3];
  int          lat[2] = '{1, 2};
  int          m_stall_cnt[2];
  int          m_fwd_cnt[2];

  logic [11:0] cur_src;
  logic [2:0]  cur_used;
  bit          cur_v, cur_fl;

  logic [5:0]  obs_f[2];
  logic        obs_st[2], obs_bb[2], obs_mlf[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input int d, output logic [5:0] f, output bit st);
    f  = '0;
    st = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int s;
      s = int'(cur_src[i*4 +: 4]);
      if (cur_used[i] && s != 15) begin
        for (int a = 0; a < 3; a++) begin
          if (hist[d][a].v && hist[d][a].rf_en && hist[d][a].rd == s) begin
            if (f[2*i +: 2] == 2'b00) f[2*i +: 2] = 2'(a + 1);
            if (hist[d][a].load && a < lat[d]) st = 1'b1;
          end
        end
      end
    end
    st = st && cur_v && !cur_fl;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 3; a++) hist[d][a] = '{0, 0, 0, 0};
      m_stall_cnt[d] = 0;
      m_fwd_cnt[d]   = 0;
    end
  endtask

  // One ID cycle: drive at posedge+1, check at negedge, advance the model, reach next posedge+1
  task automatic step(input bit rst, input bit v, input int rd, input bit rf, input bit ld,
                      input logic [11:0] src, input logic [2:0] used, input bit fl);
    logic [5:0] f_m;
    bit         st_m;
    reset = rst;
    ifa.id_valid = v;  ifb.id_valid = v;
    ifa.id_rd = 4'(rd); ifb.id_rd = 4'(rd);
    ifa.id_rf_en = rf; ifb.id_rf_en = rf;
    ifa.id_load = ld;  ifb.id_load = ld;
    ifa.id_src = src;  ifb.id_src = src;
    ifa.id_src_used = used; ifb.id_src_used = used;
    ifa.flush = fl;    ifb.flush = fl;
    cur_src = src; cur_used = used; cur_v = v; cur_fl = fl;
    #4;
    obs_f[0] = ifa.fwd_sel; obs_st[0] = ifa.stall; obs_bb[0] = ifa.bubble; obs_mlf[0] = ifa.mem_load_fwd;
    obs_f[1] = ifb.fwd_sel; obs_st[1] = ifb.stall; obs_bb[1] = ifb.bubble; obs_mlf[1] = ifb.mem_load_fwd;
    for (int d = 0; d < 2; d++) begin
      model(d, f_m, st_m);
      check_eq($sformatf("fwd_sel[lat%0d]", lat[d]), 32'(obs_f[d]), 32'(f_m));
      check_eq($sformatf("stall[lat%0d]", lat[d]), 32'(obs_st[d]), 32'(st_m));
      check_eq($sformatf("bubble[lat%0d]", lat[d]), 32'(obs_bb[d]), 32'(st_m));
      check_eq($sformatf("mem_load_fwd[lat%0d]", lat[d]), 32'(obs_mlf[d]),
               32'(hist[d][1].v && hist[d][1].load));
      if (rst) begin
        for (int a = 0; a < 3; a++) hist[d][a] = '{0, 0, 0, 0};
        m_stall_cnt[d] = 0;
        m_fwd_cnt[d]   = 0;
      end else begin
        hist[d][2] = hist[d][1];
        hist[d][1] = hist[d][0];
        hist[d][0] = (v && !st_m && !fl) ? ent_t'{1, rd, rf, ld} : ent_t'{0, 0, 0, 0};
        if (st_m) m_stall_cnt[d]++;
        if (f_m != 0) m_fwd_cnt[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reset();
    step(1, 0, 0, 0, 0, 12'h0, 3'b000, 0);
    step(1, 0, 0, 0, 0, 12'h0, 3'b000, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    @(posedge clk);
    #1;

    // Reset state
    idle_reset();
    step(0, 0, 0, 0, 0, 12'h0, 3'b000, 0);
    check_eq("rst_fwd", 32'(obs_f[0]), 32'h0);
    check_eq("rst_stall", 32'(obs_st[0]), 32'h0);
    check_eq("rst_mlf", 32'(obs_mlf[1]), 32'h0);

    // ALU result forwarded from EX, MEM, WB, then register file
    step(0, 1, 1, 1, 0, 12'h0, 3'b000, 0);
    step(0, 1, 0, 0, 0, 12'h001, 3'b001, 0);
    check_eq("alu_ex", 32'(obs_f[0][1:0]), 32'h1);
    step(0, 1, 0, 0, 0, 12'h001, 3'b001, 0);
    check_eq("alu_mem", 32'(obs_f[0][1:0]), 32'h2);
    step(0, 1, 0, 0, 0, 12'h001, 3'b001, 0);
    check_eq("alu_wb", 32'(obs_f[0][1:0]), 32'h3);
    step(0, 1, 0, 0, 0, 12'h001, 3'b001, 0);
    check_eq("alu_rf", 32'(obs_f[0][1:0]), 32'h0);

    // Load-use on src1=R2: one stall cycle at LOAD_LAT=1, two at LOAD_LAT=2
    idle_reset();
    step(0, 1, 2, 1, 1, 12'h0, 3'b000, 0);
    step(0, 1, 0, 0, 0, 12'h020, 3'b010, 0);
    check_eq("lu1_stall", 32'(obs_st[0]), 32'h1);
    check_eq("lu1_bubble", 32'(obs_bb[0]), 32'h1);
    check_eq("lu2_stall_a", 32'(obs_st[1]), 32'h1);
    step(0, 1, 0, 0, 0, 12'h020, 3'b010, 0);
    check_eq("lu1_release", 32'(obs_st[0]), 32'h0);
    check_eq("lu1_fwd_mem", 32'(obs_f[0][3:2]), 32'h2);
    check_eq("lu1_mlf", 32'(obs_mlf[0]), 32'h1);
    check_eq("lu2_stall_b", 32'(obs_st[1]), 32'h1);
    step(0, 1, 0, 0, 0, 12'h020, 3'b010, 0);
    check_eq("lu2_release", 32'(obs_st[1]), 32'h0);
    check_eq("lu2_fwd_wb", 32'(obs_f[1][3:2]), 32'h3);

    // R15 is never forwarded; youngest writer of R3 wins
    idle_reset();
    step(0, 1, 15, 1, 0, 12'h0, 3'b000, 0);
    step(0, 1, 0, 0, 0, 12'h00F, 3'b001, 0);
    check_eq("r15_nofwd", 32'(obs_f[0]), 32'h0);
    step(0, 1, 3, 1, 0, 12'h0, 3'b000, 0);
    step(0, 1, 3, 1, 0, 12'h0, 3'b000, 0);
    step(0, 1, 0, 0, 0, 12'h003, 3'b001, 0);
    check_eq("r3_youngest", 32'(obs_f[0][1:0]), 32'h1);

    // Flush beats a load-use hazard and the flushed writer never reaches EX
    idle_reset();
    step(0, 1, 2, 1, 1, 12'h0, 3'b000, 0);
    step(0, 1, 5, 1, 0, 12'h020, 3'b010, 1);
    check_eq("flush_stall", 32'(obs_st[0]), 32'h0);
    check_eq("flush_bubble", 32'(obs_bb[1]), 32'h0);
    step(0, 1, 0, 0, 0, 12'h005, 3'b001, 0);
    check_eq("flush_ex_empty", 32'(obs_f[0][1:0]), 32'h0);

    // Reset during a stall drops it on the following cycle
    idle_reset();
    step(0, 1, 2, 1, 1, 12'h0, 3'b000, 0);
    step(1, 1, 0, 0, 0, 12'h020, 3'b010, 0);
    step(0, 1, 0, 0, 0, 12'h020, 3'b010, 0);
    check_eq("rst_mid_stall", 32'(obs_st[0]), 32'h0);

    // Randomized ID stream with occasional flush and reset
    idle_reset();
    for (int n = 0; n < 600; n++) begin
      int rd;
      logic [11:0] src;
      rd  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
      src = '0;
      for (int i = 0; i < 3; i++)
        src[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 4) != 0, rd,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           src, 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
    end

`ifdef HAZ_PERF_CNT_EN
    check_eq("stall_cnt_lat1", stall_cnt_a, 32'(m_stall_cnt[0]));
    check_eq("stall_cnt_lat2", stall_cnt_b, 32'(m_stall_cnt[1]));
    check_eq("fwd_cnt_lat1", fwd_cnt_a, 32'(m_fwd_cnt[0]));
    check_eq("fwd_cnt_lat2", fwd_cnt_b, 32'(m_fwd_cnt[1]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
